// File: rtl/ysyx_22041211_core_ctrl_pkg.sv
// Shared definitions for the NPC core sequencer: FSM state encodings,
// CSR operation codes, invalid load/store codes and the reset PC.
package ysyx_22041211_core_ctrl_pkg;

    typedef enum logic [2:0] {
        CTRL_FETCH      = 3'd0,
        CTRL_FETCH_WAIT = 3'd1,
        CTRL_DECODE     = 3'd2,
        CTRL_EXEC       = 3'd3,
        CTRL_MEM_REQ    = 3'd4,
        CTRL_MEM_WAIT   = 3'd5,
        CTRL_WB         = 3'd6,
        CTRL_HALT       = 3'd7
    } ctrl_state_e;

    localparam logic [2:0]  CSR_INVALID   = 3'd0;
    localparam logic [2:0]  CSR_ECALL     = 3'd1;
    localparam logic [2:0]  CSR_CSRRW     = 3'd2;
    localparam logic [2:0]  CSR_CSRRS     = 3'd3;

    localparam logic [1:0]  STORE_INVALID = 2'd0;
    localparam logic [2:0]  LOAD_INVALID  = 3'd0;

    localparam logic [31:0] RESET_PC_DEFAULT      = 32'h8000_0000;
    localparam logic [31:0] MTVEC_DEFAULT_DEFAULT = 32'h0000_0000;

    function automatic logic is_mem_op(input logic [1:0] store_type, input logic [2:0] load_type);
        return (store_type != STORE_INVALID) || (load_type != LOAD_INVALID);
    endfunction

endpackage

// File: rtl/ysyx_22041211_core_ctrl_perf_cnt.sv
// Free-running cycle counter and retired-instruction counter, both 64-bit
// and wrapping. Only instantiated when YSYX_22041211_PERF_CNT_EN is defined.
module ysyx_22041211_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        retire,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret
);

    logic [63:0] cycle_cnt_reg;
    logic [63:0] instret_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_reg <= 64'd0;
            instret_reg   <= 64'd0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + 64'd1;
            if (retire) begin
                instret_reg <= instret_reg + 64'd1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_reg;
    assign instret   = instret_reg;

endmodule

// File: rtl/ysyx_22041211_core_ctrl.sv
// Multi-cycle NPC sequencer: owns PC and instruction latch, handshakes with
// IFU/LSU, emits WB strobes. Perf counters gated by YSYX_22041211_PERF_CNT_EN.
module ysyx_22041211_core_ctrl
    import ysyx_22041211_core_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter logic [31:0] MTVEC_DEFAULT = MTVEC_DEFAULT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid_o,
    input  logic        ifu_req_ready_i,
    output logic [31:0] ifu_addr_o,
    input  logic        ifu_rsp_valid_i,
    input  logic        ifu_rsp_err_i,
    input  logic [31:0] ifu_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    input  logic        wd_i,
    input  logic [1:0]  store_type_i,
    input  logic [2:0]  load_type_i,
    input  logic        jmp_flag_i,
    input  logic [31:0] jmp_target_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic [2:0]  csr_flag_i,
    input  logic [31:0] mtvec_i,
    output logic        lsu_req_valid_o,
    input  logic        lsu_req_ready_i,
    input  logic        lsu_rsp_valid_i,
    input  logic        lsu_rsp_err_i,
    output logic        reg_we_o,
    output logic        csr_we_o,
    output logic        trap_o,
    output logic        halt_o,
    output logic [2:0]  state_o,
    output logic [63:0] cycle_cnt_o,
    output logic [63:0] instret_o
);

    ctrl_state_e state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= CTRL_FETCH;
            pc_reg    <= RESET_PC;
            inst_reg  <= 32'd0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            inst_reg  <= inst_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        inst_next       = inst_reg;
        ifu_req_valid_o = 1'b0;
        lsu_req_valid_o = 1'b0;
        reg_we_o        = 1'b0;
        csr_we_o        = 1'b0;
        trap_o          = 1'b0;
        halt_o          = 1'b0;

        case (state_reg)
            CTRL_FETCH: begin
                ifu_req_valid_o = 1'b1;
                if (ifu_req_ready_i) begin
                    state_next = CTRL_FETCH_WAIT;
                end
            end
            CTRL_FETCH_WAIT: begin
                if (ifu_rsp_valid_i) begin
                    if (ifu_rsp_err_i) begin
                        state_next = CTRL_HALT;
                    end else begin
                        inst_next  = ifu_rdata_i;
                        state_next = CTRL_DECODE;
                    end
                end
            end
            CTRL_DECODE: begin
                state_next = CTRL_EXEC;
            end
            CTRL_EXEC: begin
                state_next = is_mem_op(store_type_i, load_type_i) ? CTRL_MEM_REQ : CTRL_WB;
            end
            CTRL_MEM_REQ: begin
                lsu_req_valid_o = 1'b1;
                if (lsu_req_ready_i) begin
                    state_next = CTRL_MEM_WAIT;
                end
            end
            CTRL_MEM_WAIT: begin
                if (lsu_rsp_valid_i) begin
                    state_next = lsu_rsp_err_i ? CTRL_HALT : CTRL_WB;
                end
            end
            CTRL_WB: begin
                reg_we_o = wd_i;
                csr_we_o = (csr_flag_i == CSR_CSRRW) || (csr_flag_i == CSR_CSRRS);
                trap_o   = (csr_flag_i == CSR_ECALL);
                // Trap outranks jump, jump outranks branch.
                if (trap_o) begin
                    pc_next = (mtvec_i == 32'd0) ? MTVEC_DEFAULT : mtvec_i;
                end else if (jmp_flag_i) begin
                    pc_next = jmp_target_i;
                end else if (branch_taken_i) begin
                    pc_next = branch_target_i;
                end else begin
                    pc_next = pc_reg + 32'd4;
                end
                state_next = CTRL_FETCH;
            end
            CTRL_HALT: begin
                halt_o = 1'b1;
            end
            default: begin
                state_next = CTRL_HALT;
            end
        endcase
    end

    assign ifu_addr_o = pc_reg;
    assign pc_o       = pc_reg;
    assign inst_o     = inst_reg;
    assign state_o    = state_reg;

`ifdef YSYX_22041211_PERF_CNT_EN
    ysyx_22041211_perf_cnt u_perf_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .retire    (state_reg == CTRL_WB),
        .cycle_cnt (cycle_cnt_o),
        .instret   (instret_o)
    );
`else
    assign cycle_cnt_o = 64'd0;
    assign instret_o   = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_22041211_core_ctrl.sv
// Scoreboard bench for the core sequencer: stimulus queues expected WB results,
// a monitor checks them when the DUT reaches WB.
module tb_ysyx_22041211_core_ctrl;

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_MEM_REQ = 3'd4;
    localparam logic [2:0] S_WB      = 3'd6;
    localparam logic [2:0] S_HALT    = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid_o, ifu_req_ready_i, ifu_rsp_valid_i, ifu_rsp_err_i;
    logic [31:0] ifu_addr_o, ifu_rdata_i, inst_o, pc_o;
    logic        wd_i, jmp_flag_i, branch_taken_i;
    logic [1:0]  store_type_i;
    logic [2:0]  load_type_i, csr_flag_i;
    logic [31:0] jmp_target_i, branch_target_i, mtvec_i;
    logic        lsu_req_valid_o, lsu_req_ready_i, lsu_rsp_valid_i, lsu_rsp_err_i;
    logic        reg_we_o, csr_we_o, trap_o, halt_o;
    logic [2:0]  state_o;
    logic [63:0] cycle_cnt_o, instret_o;

    ysyx_22041211_core_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid_o(ifu_req_valid_o), .ifu_req_ready_i(ifu_req_ready_i),
        .ifu_addr_o(ifu_addr_o), .ifu_rsp_valid_i(ifu_rsp_valid_i),
        .ifu_rsp_err_i(ifu_rsp_err_i), .ifu_rdata_i(ifu_rdata_i),
        .inst_o(inst_o), .pc_o(pc_o), .wd_i(wd_i),
        .store_type_i(store_type_i), .load_type_i(load_type_i),
        .jmp_flag_i(jmp_flag_i), .jmp_target_i(jmp_target_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .csr_flag_i(csr_flag_i), .mtvec_i(mtvec_i),
        .lsu_req_valid_o(lsu_req_valid_o), .lsu_req_ready_i(lsu_req_ready_i),
        .lsu_rsp_valid_i(lsu_rsp_valid_i), .lsu_rsp_err_i(lsu_rsp_err_i),
        .reg_we_o(reg_we_o), .csr_we_o(csr_we_o), .trap_o(trap_o), .halt_o(halt_o),
        .state_o(state_o), .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        reg_we;
        logic        csr_we;
        logic        trap;
        logic [31:0] inst;
        logic [31:0] npc;
        int          lat;
        int          lsu;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn_id = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s);
        int n = 0;
        while (state_o !== s && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (state_o !== s) begin
            checks++;
            errors++;
            $display("FAIL wait_state timeout: state %0d, wanted %0d", state_o, s);
        end
    endtask

    // Monitor: samples 1 time unit after each falling edge.
    initial begin
        exp_t        e;
        int          mcyc = 0, start = 0, lsu_cnt = 0;
        logic        pend = 1'b0;
        logic [31:0] exp_pc = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                mcyc++;
                if (pend) begin
                    chk("pc_after_wb", pc_o, exp_pc);
                    pend = 1'b0;
                end
                if (lsu_req_valid_o) lsu_cnt++;
                if (ifu_req_valid_o && ifu_req_ready_i) begin
                    start   = mcyc;
                    lsu_cnt = 0;
                end
                if (state_o != S_WB)
                    chk("no_strobe_outside_wb", {reg_we_o, csr_we_o, trap_o}, 3'b000);
                if (state_o == S_WB) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_wb", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("reg_we", reg_we_o, e.reg_we);
                        chk("csr_we", csr_we_o, e.csr_we);
                        chk("trap", trap_o, e.trap);
                        chk("inst_o", inst_o, e.inst);
                        chk("wb_latency", mcyc - start, e.lat);
                        chk("lsu_valid_cycles", lsu_cnt, e.lsu);
                        exp_pc = e.npc;
                        pend   = 1'b1;
                        $display("txn %0d inst=%08h we=%0d csr_we=%0d trap=%0d next_pc=%08h",
                                 e.id, e.inst, reg_we_o, csr_we_o, trap_o, e.npc);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic run_inst(input logic [31:0] inst, input logic wd, input logic [1:0] st,
                            input logic [2:0] ld, input logic jmp, input logic [31:0] jt,
                            input logic bt, input logic [31:0] bta, input logic [2:0] csr,
                            input logic [31:0] mtv, input int dly, input logic lerr,
                            input logic [31:0] npc);
        exp_t e;
        logic mem;
        mem = (st != 2'd0) || (ld != 3'd0);
        wd_i = wd; store_type_i = st; load_type_i = ld;
        jmp_flag_i = jmp; jmp_target_i = jt; branch_taken_i = bt; branch_target_i = bta;
        csr_flag_i = csr; mtvec_i = mtv;
        wait_state(S_FETCH);
        if (!lerr) begin
            txn_id++;
            e.id = txn_id; e.reg_we = wd; e.csr_we = (csr == 3'd2) || (csr == 3'd3);
            e.trap = (csr == 3'd1); e.inst = inst; e.npc = npc;
            e.lat = mem ? 6 + dly : 4;
            e.lsu = mem ? dly + 1 : 0;
            exp_q.push_back(e);
        end
        ifu_req_ready_i = 1'b1;
        @(negedge clk);
        ifu_req_ready_i = 1'b0; ifu_rsp_valid_i = 1'b1; ifu_rdata_i = inst;
        @(negedge clk);
        ifu_rsp_valid_i = 1'b0;
        if (mem) begin
            wait_state(S_MEM_REQ);
            repeat (dly) @(negedge clk);
            lsu_req_ready_i = 1'b1;
            @(negedge clk);
            lsu_req_ready_i = 1'b0; lsu_rsp_valid_i = 1'b1; lsu_rsp_err_i = lerr;
            @(negedge clk);
            lsu_rsp_valid_i = 1'b0; lsu_rsp_err_i = 1'b0;
            if (lerr) begin
                chk("lsu_err_halt_state", state_o, S_HALT);
                chk("lsu_err_halt_o", halt_o, 1'b1);
                return;
            end
        end else begin
            wait_state(S_WB);
        end
        @(negedge clk);
    endtask

    task automatic alu(input logic [31:0] npc);
        run_inst(32'h0010_0093, 1'b1, 2'd0, 3'd0, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0, 32'd0, 0, 1'b0, npc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        ifu_req_ready_i = 0; ifu_rsp_valid_i = 0; ifu_rsp_err_i = 0; ifu_rdata_i = 0;
        wd_i = 0; store_type_i = 0; load_type_i = 0; jmp_flag_i = 0; jmp_target_i = 0;
        branch_taken_i = 0; branch_target_i = 0; csr_flag_i = 0; mtvec_i = 0;
        lsu_req_ready_i = 0; lsu_rsp_valid_i = 0; lsu_rsp_err_i = 0;

        repeat (2) @(negedge clk);
        chk("reset_pc", pc_o, 32'h8000_0000);
        chk("reset_state", state_o, S_FETCH);
        chk("reset_inst", inst_o, 32'd0);
        chk("reset_ifu_req_valid", ifu_req_valid_o, 1'b1);
        chk("reset_strobes", {reg_we_o, csr_we_o, trap_o, lsu_req_valid_o}, 4'b0);
        chk("reset_halt", halt_o, 1'b0);
        chk("reset_counters", cycle_cnt_o | instret_o, 64'd0);
        rst_n = 1'b1;

        alu(32'h8000_0004);
        // load, lsu ready delayed 3 cycles
        run_inst(32'h0000_2103, 1'b1, 2'd0, 3'd1, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0, 32'd0, 3, 1'b0, 32'h8000_0008);
        // store, no delay
        run_inst(32'h0020_2023, 1'b0, 2'd1, 3'd0, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0, 32'd0, 0, 1'b0, 32'h8000_000C);
        // jal with branch also taken: jump wins
        run_inst(32'h0f40_00ef, 1'b1, 2'd0, 3'd0, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0300, 3'd0, 32'd0, 0, 1'b0, 32'h8000_0100);
        // branch taken alone
        run_inst(32'hf800_0063, 1'b0, 2'd0, 3'd0, 1'b0, 32'd0, 1'b1, 32'h8000_0080, 3'd0, 32'd0, 0, 1'b0, 32'h8000_0080);
        // ecall with jump also flagged: trap wins
        run_inst(32'h0000_0073, 1'b0, 2'd0, 3'd0, 1'b1, 32'h8000_0040, 1'b0, 32'd0, 3'd1, 32'h8000_0200, 0, 1'b0, 32'h8000_0200);
        // ecall with mtvec zero: default vector
        run_inst(32'h0000_0073, 1'b0, 2'd0, 3'd0, 1'b0, 32'd0, 1'b0, 32'd0, 3'd1, 32'd0, 0, 1'b0, 32'h0000_0000);
        run_inst(32'h3050_10f3, 1'b1, 2'd0, 3'd0, 1'b0, 32'd0, 1'b0, 32'd0, 3'd2, 32'd0, 0, 1'b0, 32'h0000_0004);
        run_inst(32'h3050_20f3, 1'b1, 2'd0, 3'd0, 1'b0, 32'd0, 1'b0, 32'd0, 3'd3, 32'd0, 0, 1'b0, 32'h0000_0008);
        run_inst(32'h0000_006f, 1'b1, 2'd0, 3'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 3'd0, 32'd0, 0, 1'b0, 32'hFFFF_FFFC);
        alu(32'h0000_0000);
        // load whose LSU response carries an error
        run_inst(32'h0000_2103, 1'b1, 2'd0, 3'd1, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0, 32'd0, 0, 1'b1, 32'd0);
        do_reset();

        // fetch bus error: halt, hold, then async reset mid-halt
        wait_state(S_FETCH);
        ifu_req_ready_i = 1'b1;
        @(negedge clk);
        ifu_req_ready_i = 1'b0; ifu_rsp_valid_i = 1'b1; ifu_rsp_err_i = 1'b1; ifu_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        ifu_rsp_valid_i = 1'b0; ifu_rsp_err_i = 1'b0;
        ifu_req_ready_i = 1'b1; lsu_req_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("halt_state", state_o, S_HALT);
            chk("halt_o", halt_o, 1'b1);
            chk("halt_no_requests", {ifu_req_valid_o, lsu_req_valid_o}, 2'b00);
            @(negedge clk);
        end
        chk("halt_inst_unchanged", inst_o, 32'd0);
        ifu_req_ready_i = 1'b0; lsu_req_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_pc", pc_o, 32'h8000_0000);
        chk("async_reset_state", state_o, S_FETCH);
        chk("async_reset_halt", halt_o, 1'b0);
        chk("async_reset_ifu_valid", ifu_req_valid_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        alu(32'h8000_0004);

        do_reset();
        for (int i = 1; i <= 10; i++) alu(32'h8000_0000 + 32'(4 * i));
`ifdef YSYX_22041211_PERF_CNT_EN
        chk("instret", instret_o, 64'd10);
        chk("cycle_cnt", cycle_cnt_o, 64'd50);
`else
        chk("instret_tied", instret_o, 64'd0);
        chk("cycle_cnt_tied", cycle_cnt_o, 64'd0);
`endif
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
